fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter: INC, default 2, byte increment added to the PC for sequential fetch.
REQ-002 SHALL have clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have pc  input  16  current PC value read back from the PC register.
REQ-005 SHALL have next_pc  output  16  value the PC register loads.
REQ-006 SHALL have pc_en  output  1  PC register write enable.
REQ-007 SHALL have imem_req  output  1  instruction-memory request.
REQ-008 SHALL have imem_addr  output  16  request address.
REQ-009 SHALL have imem_ready  input  1  memory completion; imem_data is valid this cycle.
REQ-010 SHALL have imem_data  input  16  fetched instruction word.
REQ-011 SHALL have stall  input  1  decode cannot accept a new instruction this cycle.
REQ-012 SHALL have redirect  input  1  single-cycle taken-branch/jump pulse.
REQ-013 SHALL have branch_target  input  16  new PC, valid with redirect.
REQ-014 SHALL have halt  input  1  decode has a HLT instruction.
REQ-015 SHALL have instr  output  16  instruction to decode, registered.
REQ-016 SHALL have instr_valid  output  1  instr holds a live instruction.

Function
REQ-017 SHALL implement states START, FETCH, HOLD, DRAIN, HALTED.
REQ-018 SHALL hold imem_addr from an internal req_addr register; once imem_req is high, imem_addr stays stable until the imem_ready cycle.
REQ-019 SHALL assert imem_req only in FETCH and DRAIN.
REQ-020 START: imem_req 0, pc_en 0; next cycle go to FETCH with req_addr <= pc.
REQ-021 FETCH, imem_ready & ~stall: instr <= imem_data, instr_valid <= 1, pc_en=1, next_pc=pc+INC, req_addr <= pc+INC; stay in FETCH, so back-to-back fetch gives one instruction per cycle.
REQ-022 FETCH, imem_ready & stall: capture imem_data into a one-entry buffer; pc_en 0; instr and instr_valid unchanged; go to HOLD.
REQ-023 FETCH, ~imem_ready: no state change, pc_en 0.
REQ-024 HOLD, ~stall: instr <= buffer, instr_valid <= 1, pc_en=1, next_pc=pc+INC, req_addr <= pc+INC; go to FETCH.
REQ-025 HOLD, stall: hold everything.
REQ-026 Redirect has priority over all except HALTED, where it is ignored.
REQ-027 On redirect: pc_en=1, next_pc=branch_target, instr_valid <= 0, buffer discarded.
REQ-028 Redirect from FETCH-with-imem_ready, HOLD or START: go to FETCH with req_addr <= branch_target.
REQ-029 Redirect from FETCH-without-imem_ready: go to DRAIN, keeping the outstanding request.
REQ-030 Redirect in DRAIN: reload the PC again; remain in DRAIN.
REQ-031 DRAIN: discard imem_data; when imem_ready, go to FETCH with req_addr <= pc, or to HALTED if halt is latched.
REQ-032 Halt (without redirect) from FETCH-with-imem_ready, HOLD or START: go to HALTED; data discarded; instr_valid <= 0.
REQ-033 Halt from FETCH-without-imem_ready: latch halt and go to DRAIN.
REQ-034 HALTED: imem_req 0, pc_en 0, instr_valid 0; exit only by reset.
REQ-035 When pc_en is 0, next_pc SHALL equal pc.
REQ-036 pc+INC SHALL wrap modulo 2^16 (0xFFFE+2 = 0x0000).
REQ-037 Simultaneous redirect and halt: redirect wins and the halt is ignored.
REQ-038 Simultaneous redirect and stall: redirect wins.

Reset
REQ-039 While rst_n=0: state START, instr 0x0000, instr_valid 0, req_addr 0x0000, buffer cleared, halt latch cleared; imem_req 0, pc_en 0, next_pc=pc.
REQ-040 Reset assertion mid-request SHALL abandon the request immediately; no memory response is delivered after reset.

Verification
REQ-041 Reset release with pc=0x0000 and imem_ready tied 1 -> imem_addr 0x0000, 0x0002, 0x0004 on consecutive cycles; instr_valid 1 from the second cycle after START.
REQ-042 imem_ready at pc=0x0010 with stall held 3 cycles -> HOLD; pc stays 0x0010 and pc_en 0; one cycle after stall drops, instr = buffered word and pc_en pulses once (0x0012).
REQ-043 redirect to 0x0100 while a request to 0x0020 is outstanding, ready 2 cycles later -> the 0x0020 data is never on instr; next imem_addr is 0x0100.
REQ-044 pc=0xFFFE, data returned, no stall -> next_pc 0x0000 and next imem_addr 0x0000.
REQ-045 halt asserted in FETCH without ready -> DRAIN, then HALTED after ready; imem_req stays 0 for 10 further cycles even with redirect pulsed.
REQ-046 redirect and halt in the same cycle with branch_target 0x0040 -> pc loads 0x0040 and fetch continues; HALTED is not entered.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the PC register write port and a single
// outstanding instruction-memory request. It also handles the stall buffer, redirect drain and halt.
module fetch_ctrl #(
    parameter int unsigned INC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc,
    output logic [15:0] next_pc,
    output logic        pc_en,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] branch_target,
    input  logic        halt,
    output logic [15:0] instr,
    output logic        instr_valid
);

    typedef enum logic [2:0] {StStart, StFetch, StHold, StDrain, StHalted} state_e;

    localparam logic [15:0] IncStep = 16'(INC);

    state_e      state_q;
    logic [15:0] req_addr_q;
    logic [15:0] buffer_q;
    logic        halt_q;
    logic [15:0] pc_inc;
    logic        redir;
    logic        advance;

    assign pc_inc = pc + IncStep;

    // A redirect reloads the PC in every live state. A sequential advance happens only when an
    // instruction actually moves into instr.
    assign redir   = rst_n && redirect && (state_q != StHalted);
    assign advance = rst_n && !redirect && !halt &&
                     (((state_q == StFetch) && imem_ready && !stall) ||
                      ((state_q == StHold) && !stall));

    always_comb begin
        pc_en   = 1'b0;
        next_pc = pc;
        if (redir) begin
            pc_en   = 1'b1;
            next_pc = branch_target;
        end else if (advance) begin
            pc_en   = 1'b1;
            next_pc = pc_inc;
        end
    end

    assign imem_req  = (state_q == StFetch) || (state_q == StDrain);
    assign imem_addr = req_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StStart;
            req_addr_q  <= '0;
            buffer_q    <= '0;
            halt_q      <= 1'b0;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            unique case (state_q)
                StStart: begin
                    if (redirect) begin
                        state_q     <= StFetch;
                        req_addr_q  <= branch_target;
                        instr_valid <= 1'b0;
                    end else if (halt) begin
                        state_q     <= StHalted;
                        instr_valid <= 1'b0;
                    end else begin
                        state_q    <= StFetch;
                        req_addr_q <= pc;
                    end
                end
                StFetch: begin
                    if (redirect) begin
                        instr_valid <= 1'b0;
                        buffer_q    <= '0;
                        // An unanswered request must complete before a new address is issued.
                        if (imem_ready) begin
                            req_addr_q <= branch_target;
                        end else begin
                            state_q <= StDrain;
                        end
                    end else if (halt) begin
                        instr_valid <= 1'b0;
                        if (imem_ready) begin
                            state_q <= StHalted;
                        end else begin
                            halt_q  <= 1'b1;
                            state_q <= StDrain;
                        end
                    end else if (imem_ready) begin
                        if (stall) begin
                            buffer_q <= imem_data;
                            state_q  <= StHold;
                        end else begin
                            instr       <= imem_data;
                            instr_valid <= 1'b1;
                            req_addr_q  <= pc_inc;
                        end
                    end
                end
                StHold: begin
                    if (redirect) begin
                        instr_valid <= 1'b0;
                        buffer_q    <= '0;
                        req_addr_q  <= branch_target;
                        state_q     <= StFetch;
                    end else if (halt) begin
                        instr_valid <= 1'b0;
                        state_q     <= StHalted;
                    end else if (!stall) begin
                        instr       <= buffer_q;
                        instr_valid <= 1'b1;
                        req_addr_q  <= pc_inc;
                        state_q     <= StFetch;
                    end
                end
                StDrain: begin
                    if (redirect) begin
                        halt_q <= 1'b0;
                    end else if (imem_ready) begin
                        if (halt_q) begin
                            state_q <= StHalted;
                        end else begin
                            state_q    <= StFetch;
                            req_addr_q <= pc;
                        end
                    end
                end
                StHalted: begin
                    instr_valid <= 1'b0;
                end
                default: begin
                    state_q <= StStart;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: models the PC register and the instruction memory.
// It checks that the delivered instruction stream follows program order through a scoreboard.
module tb_fetch_ctrl;

    localparam int unsigned INC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc = 16'h0;
    logic [15:0] next_pc;
    logic        pc_en;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [15:0] imem_data = 16'h0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] branch_target = 16'h0;
    logic        halt = 1'b0;
    logic [15:0] instr;
    logic        instr_valid;

    logic        pc_load = 1'b0;
    logic [15:0] pc_load_val = 16'h0;

    typedef struct {
        bit          redir;
        logic [15:0] npc;
        logic [15:0] word;
    } exp_t;

    exp_t sb_q[$];
    bit   model_halted = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_deliver = 0;

    fetch_ctrl #(.INC(INC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc           (pc),
        .next_pc      (next_pc),
        .pc_en        (pc_en),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_data    (imem_data),
        .stall        (stall),
        .redirect     (redirect),
        .branch_target(branch_target),
        .halt         (halt),
        .instr        (instr),
        .instr_valid  (instr_valid)
    );

    always #5 clk = ~clk;

    // PC register owned by the bench; pc_load lets directed tests place the PC anywhere.
    always @(posedge clk) begin
        if (pc_load) pc <= pc_load_val;
        else if (pc_en) pc <= next_pc;
    end

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // One cycle of stimulus. Whatever the architecture says must later reach the PC port is
    // queued here.
    task automatic step(input bit rdy, input bit st, input bit rd, input logic [15:0] tgt,
                        input bit hl);
        logic [15:0] t;
        @(posedge clk);
        #1;
        t = tgt;
        if (rd) begin
            while (t == pc || t == imem_addr) t = t + 16'h0002;
        end
        imem_ready    = rdy;
        imem_data     = rdy ? mem_word(imem_addr) : 16'($urandom);
        stall         = st;
        redirect      = rd;
        branch_target = t;
        halt          = hl;
        if (!model_halted) begin
            if (rd) begin
                sb_q.delete();
                sb_q.push_back('{redir: 1'b1, npc: t, word: 16'h0});
            end else if (hl) begin
                sb_q.delete();
                model_halted = 1'b1;
            end else if (imem_req && rdy && imem_addr == pc) begin
                sb_q.push_back('{redir: 1'b0, npc: pc + 16'(INC), word: mem_word(pc)});
            end
        end
    endtask

    task automatic do_reset(input logic [15:0] start_pc);
        @(posedge clk);
        #1;
        rst_n         = 1'b0;
        pc_load       = 1'b1;
        pc_load_val   = start_pc;
        imem_ready    = 1'b1;
        imem_data     = 16'hDEAD;
        redirect      = 1'b1;
        halt          = 1'b1;
        stall         = 1'b0;
        branch_target = 16'h0BAD;
        sb_q.delete();
        model_halted  = 1'b0;
        #1;
        chk1("rst_abandons_req", imem_req, 1'b0);
        chk1("rst_pc_en", pc_en, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk16("rst_next_pc_eq_pc", next_pc, start_pc);
        chk16("rst_instr", instr, 16'h0000);
        chk1("rst_instr_valid", instr_valid, 1'b0);
        chk16("rst_imem_addr", imem_addr, 16'h0000);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        pc_load    = 1'b0;
        redirect   = 1'b0;
        halt       = 1'b0;
        imem_ready = 1'b0;
    endtask

    // Monitor: pops one scoreboard entry per PC write and checks the resulting instruction.
    initial begin
        exp_t        e;
        bit          pend_v = 1'b0;
        bit          pend_kill = 1'b0;
        logic [15:0] pend_word = 16'h0;
        bit          prev_wait = 1'b0;
        logic [15:0] prev_addr = 16'h0;
        int          age = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend_v    = 1'b0;
                pend_kill = 1'b0;
                prev_wait = 1'b0;
                age       = 0;
            end else begin
                if (pend_v) begin
                    chk16("deliver_instr", instr, pend_word);
                    chk1("deliver_valid", instr_valid, 1'b1);
                    pend_v = 1'b0;
                end
                if (pend_kill) begin
                    chk1("redirect_clears_valid", instr_valid, 1'b0);
                    pend_kill = 1'b0;
                end
                if (prev_wait) begin
                    chk1("req_held", imem_req, 1'b1);
                    chk16("req_addr_stable", imem_addr, prev_addr);
                end
                prev_wait = imem_req && !imem_ready;
                prev_addr = imem_addr;
                if (pc_en) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_pc_en: got pc_en=1 next_pc=%h expected pc_en=0",
                                 next_pc);
                    end else begin
                        e = sb_q.pop_front();
                        chk16("next_pc", next_pc, e.npc);
                        if (e.redir) pend_kill = 1'b1;
                        else begin
                            pend_word = e.word;
                            pend_v    = 1'b1;
                            n_deliver++;
                        end
                    end
                end else begin
                    chk16("next_pc_hold", next_pc, pc);
                end
                if (sb_q.size() > 0) age++;
                else age = 0;
                if (age > 60) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL delivery_timeout: got no pc_en in 60 cycles expected pc_en=1");
                    sb_q.delete();
                    age = 0;
                end
            end
        end
    end

    initial begin
        // Reset release, then back-to-back sequential fetch.
        do_reset(16'h0000);
        @(negedge clk);
        chk1("start_no_req", imem_req, 1'b0);
        chk1("start_no_pc_en", pc_en, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
            @(negedge clk);
            chk1("seq_req", imem_req, 1'b1);
            chk16("seq_addr", imem_addr, 16'(2 * i));
            if (i > 0) chk1("seq_valid", instr_valid, 1'b1);
        end

        // Stall when data returns, held three cycles.
        do_reset(16'h0010);
        step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        chk1("stall_capture_pc_en", pc_en, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
            @(negedge clk);
            chk1("hold_pc_en", pc_en, 1'b0);
            chk16("hold_pc", pc, 16'h0010);
            chk1("hold_no_req", imem_req, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        chk1("unstall_pc_en", pc_en, 1'b1);
        chk16("unstall_next_pc", next_pc, 16'h0012);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        chk16("unstall_instr", instr, mem_word(16'h0010));
        chk1("unstall_pulse_once", pc_en, 1'b0);
        chk16("unstall_pc", pc, 16'h0012);

        // Redirect while a request is outstanding: the old word must be drained and discarded.
        do_reset(16'h0020);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h0100, 1'b0);
        @(negedge clk);
        chk16("drain_redirect_next_pc", next_pc, 16'h0100);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        chk16("drain_keeps_addr", imem_addr, 16'h0020);
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        chk1("drain_discard_pc_en", pc_en, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        chk16("after_drain_addr", imem_addr, 16'h0100);
        chk1("after_drain_valid", instr_valid, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        chk16("after_drain_instr", instr, mem_word(16'h0100));

        // PC wrap-around.
        do_reset(16'hFFFE);
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        chk16("wrap_next_pc", next_pc, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        chk16("wrap_addr", imem_addr, 16'h0000);

        // Halt with a request outstanding; reset here also lands mid-request.
        do_reset(16'h0030);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        @(negedge clk);
        chk1("halt_pc_en", pc_en, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        chk1("halt_drain_req", imem_req, 1'b1);
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'($urandom_range(0, 1)), 1'b0, (i % 3) == 0, 16'($urandom) & 16'hFFFE, 1'b0);
            @(negedge clk);
            chk1("halted_no_req", imem_req, 1'b0);
            chk1("halted_no_pc_en", pc_en, 1'b0);
            chk1("halted_no_valid", instr_valid, 1'b0);
        end

        // Redirect and halt together: the redirect wins.
        do_reset(16'h0050);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 16'h0040, 1'b1);
        @(negedge clk);
        chk16("redir_halt_next_pc", next_pc, 16'h0040);
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        chk16("redir_halt_addr", imem_addr, 16'h0040);
        chk1("redir_halt_fetching", pc_en, 1'b1);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        chk16("redir_halt_instr", instr, mem_word(16'h0040));

        // Randomized traffic with one reset in the middle.
        do_reset(16'($urandom) & 16'hFFFE);
        for (int c = 0; c < 1500; c++) begin
            if (c == 750) do_reset(16'($urandom) & 16'hFFFE);
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 6, 16'($urandom) & 16'hFFFE, 1'b0);
        end
        for (int c = 0; c < 20; c++) step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        #1;
        chk16("scoreboard_empty", 16'(sb_q.size()), 16'h0000);
        chk1("enough_deliveries", n_deliver >= 200, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no end of test expected completion");
        $fatal(1, "timeout");
    end

endmodule
